// File: rtl/writeback.sv
// Writeback stage: one-deep result register, 32-entry register file, per-register
// pending-write scoreboard, and combinational decode read ports with commit bypass.
module writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              claim_valid,
  output logic              claim_ready,
  input  logic [ADDR_W-1:0] claim_dest,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_hazard,
  output logic [31:0]       retire_count,
  output logic              sb_error
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              q_valid_q, q_valid_d;
  logic [ADDR_W-1:0] q_dest_q, q_dest_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;
  logic [DATA_W-1:0] regfile_q [NREG];
  logic [DATA_W-1:0] regfile_d [NREG];
  logic [CNT_W-1:0]  pending_q [NREG];
  logic [CNT_W-1:0]  pending_d [NREG];
  logic [31:0]       retire_count_q, retire_count_d;
  logic              sb_error_q, sb_error_d;

  logic              accept;
  logic              claim_fire;
  logic              commit_nz;
  logic              byp_1, byp_2;
  logic [CNT_W-1:0]  pend_1, pend_2;
  logic              haz_1, haz_2;

  assign wb_ready    = ~rst;
  assign accept      = wb_valid & wb_ready;
  assign claim_ready = (pending_q[claim_dest] != CNT_MAX);
  assign claim_fire  = claim_valid & claim_ready & (claim_dest != '0);
  assign commit_nz   = q_valid_q & (q_dest_q != '0);

  always_comb begin
    q_valid_d = accept;
    q_dest_d  = q_dest_q;
    q_data_d  = q_data_q;
    if (accept) begin
      q_dest_d = wb_dest;
      q_data_d = wb_data;
    end
  end

  // Decrement on commit first, then increment on claim, so a same-register
  // claim and commit in one cycle cancel out.
  always_comb begin
    regfile_d      = regfile_q;
    pending_d      = pending_q;
    retire_count_d = retire_count_q;
    sb_error_d     = sb_error_q;
    if (q_valid_q) retire_count_d = retire_count_q + 32'd1;
    if (commit_nz) begin
      regfile_d[q_dest_q] = q_data_q;
      if (pending_q[q_dest_q] == '0) sb_error_d = 1'b1;
      else pending_d[q_dest_q] = pending_q[q_dest_q] - CNT_ONE;
    end
    if (claim_fire) pending_d[claim_dest] = pending_d[claim_dest] + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid_q      <= 1'b0;
      q_dest_q       <= '0;
      q_data_q       <= '0;
      retire_count_q <= '0;
      sb_error_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regfile_q[i] <= '0;
        pending_q[i] <= '0;
      end
    end else begin
      q_valid_q      <= q_valid_d;
      q_dest_q       <= q_dest_d;
      q_data_q       <= q_data_d;
      retire_count_q <= retire_count_d;
      sb_error_q     <= sb_error_d;
      regfile_q      <= regfile_d;
      pending_q      <= pending_d;
    end
  end

  assign byp_1 = q_valid_q & (q_dest_q == rd_addr_1) & (rd_addr_1 != '0);
  assign byp_2 = q_valid_q & (q_dest_q == rd_addr_2) & (rd_addr_2 != '0);
  assign pend_1 = pending_q[rd_addr_1];
  assign pend_2 = pending_q[rd_addr_2];

  assign rd_data_1 = byp_1 ? q_data_q : regfile_q[rd_addr_1];
  assign rd_data_2 = byp_2 ? q_data_q : regfile_q[rd_addr_2];

  // A single outstanding write is resolved once its result is being bypassed.
  assign haz_1 = (rd_addr_1 != '0) & ((pend_1 > CNT_ONE) | ((pend_1 == CNT_ONE) & ~byp_1));
  assign haz_2 = (rd_addr_2 != '0) & ((pend_2 > CNT_ONE) | ((pend_2 == CNT_ONE) & ~byp_2));
  assign rd_hazard = haz_1 | haz_2;

  assign retire_count = retire_count_q;
  assign sb_error     = sb_error_q;

endmodule
